align_unit_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-channel scan alignment unit.
- Each of CH data lanes is delayed by its own programmable sample count through an internal circular buffer. All lanes are released on one common valid strobe.
- Sits between the acquisition/simulation data mux and downstream packing logic. Gives per-channel skew correction with a fill/run state machine and configuration error reporting.

---
 rtl/align_unit_mc.sv | 100 ++++++++++
 tb/tb_align_unit_mc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/align_unit_mc.sv
// align_unit_mc: delays each of CH lanes by its own sample count through a per-lane circular buffer.
// Fill/run sequencing releases all lanes on one strobe; a sticky flag reports clamped delay settings.
module align_unit_mc #(
    parameter int CH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       data_sim_en_i,
    input  logic [CH*DATA_WIDTH-1:0]   data_sim_i,
    input  logic                       data_en_i,
    input  logic [CH*DATA_WIDTH-1:0]   data_i,
    input  logic                       align_start_en_i,
    input  logic                       align_rst_i,
    input  logic [CH*16-1:0]           align_set_i,
    output logic                       align_data_en_o,
    output logic [CH*DATA_WIDTH-1:0]   align_data_o,
    output logic [1:0]                 align_state_o,
    output logic                       align_err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

    state_t                     state;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              fill_cnt;
    logic [AW-1:0]              fill_nxt;
    logic [AW-1:0]              dmax;
    logic [CH-1:0][AW-1:0]      dly;
    logic [CH-1:0][AW-1:0]      set_clamp;
    logic [CH-1:0]              clamped;
    logic [CH*DATA_WIDTH-1:0]   din;
    logic [CH*DATA_WIDTH-1:0]   rd_word;
    logic                       s;
    logic                       go;
    logic                       wr;
    logic                       rd_v;

    assign s        = data_en_i | data_sim_en_i;
    assign din      = data_sim_en_i ? data_sim_i : data_i;
    assign go       = (state != IDLE) && align_start_en_i;
    assign wr       = go && s;
    assign fill_nxt = (s && fill_cnt != AW'(DEPTH - 1)) ? fill_cnt + AW'(1) : fill_cnt;
    assign align_state_o = state;

    always_comb begin
        dmax = '0;
        for (int c = 0; c < CH; c++) dmax = (dly[c] > dmax) ? dly[c] : dmax;
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] wdat;
        logic [DATA_WIDTH-1:0] rd_q;
        assign wdat         = din[c*DATA_WIDTH +: DATA_WIDTH];
        assign clamped[c]   = align_set_i[c*16 +: 16] > 16'(DEPTH - 1);
        assign set_clamp[c] = clamped[c] ? AW'(DEPTH - 1) : align_set_i[c*16 +: AW];
        assign rd_word[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
        // zero delay reads the slot being written, so forward the incoming word
        always_ff @(posedge clk_i) begin
            if (wr) mem[wr_ptr] <= wdat;
            if (wr && state == RUN) rd_q <= (dly[c] == '0) ? wdat : mem[wr_ptr - dly[c]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || align_rst_i) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            fill_cnt        <= '0;
            rd_v            <= 1'b0;
            align_data_en_o <= 1'b0;
            align_data_o    <= '0;
            align_err_o     <= 1'b0;
            if (!rst_n_i) dly <= '0;
        end else begin
            rd_v            <= wr && state == RUN;
            align_data_en_o <= rd_v && go;
            align_data_o    <= (rd_v && go) ? rd_word : align_data_o;
            wr_ptr          <= wr ? wr_ptr + AW'(1) : wr_ptr;
            case (state)
                IDLE: if (align_start_en_i) begin
                    dly         <= set_clamp;
                    align_err_o <= align_err_o | (|clamped);
                    fill_cnt    <= '0;
                    state       <= FILL;
                end
                FILL: if (!align_start_en_i) state <= IDLE;
                      else begin
                          fill_cnt <= fill_nxt;
                          if (fill_nxt >= dmax) state <= RUN;
                      end
                RUN:  if (!align_start_en_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_align_unit_mc.sv
// tb_align_unit_mc: randomized scoreboard bench; a sample-history model predicts each aligned word
// and its arrival cycle, and a negedge monitor matches DUT output against the queue.
module tb_align_unit_mc;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int W = CH * DW;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n, arst, start, den, sen;
    logic [W-1:0]    d, sd;
    logic [CH*16-1:0] set;
    logic            align_data_en;
    logic [W-1:0]    align_data;
    logic [1:0]      align_state;
    logic            align_err;

    int              cyc = 0;
    int              compared = 0;
    int              fails = 0;
    int              zero_due = -1;
    exp_t            q[$];
    exp_t            em;
    logic [W-1:0]    mlast = '0;

    int              mstate = 0;
    bit              merr = 1'b0;
    int              md[CH];
    int              mdmax;
    int              n;
    logic [W-1:0]    hist[$];

    align_unit_mc #(.CH(CH), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_sim_en_i(sen), .data_sim_i(sd),
        .data_en_i(den), .data_i(d), .align_start_en_i(start), .align_rst_i(arst),
        .align_set_i(set), .align_data_en_o(align_data_en), .align_data_o(align_data),
        .align_state_o(align_state), .align_err_o(align_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc == zero_due) mlast = '0;
        while (q.size() != 0 && q[0].due < cyc) begin
            compared++;
            fails++;
            $display("FAIL missing_valid cyc=%0d due=%0d exp=%h", cyc, q[0].due, q[0].data);
            void'(q.pop_front());
        end
        compared++;
        if (align_data_en === 1'b1) begin
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid cyc=%0d got=%h", cyc, align_data);
            end else begin
                em = q.pop_front();
                if (em.due != cyc || align_data !== em.data) begin
                    fails++;
                    $display("FAIL aligned_data cyc=%0d due=%0d got=%h exp=%h", cyc, em.due, align_data, em.data);
                end
                mlast = em.data;
            end
        end else if (align_data_en !== 1'b0 || align_data !== mlast) begin
            fails++;
            $display("FAIL hold cyc=%0d en=%b got=%h exp=%h", cyc, align_data_en, align_data, mlast);
        end
    end

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*DW +: DW] = $urandom;
        return r;
    endfunction

    function automatic logic [CH*16-1:0] rset(input int hi);
        logic [CH*16-1:0] r;
        for (int c = 0; c < CH; c++) r[c*16 +: 16] = 16'($urandom_range(0, hi));
        return r;
    endfunction

    task automatic kill();
        while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
    endtask

    task automatic step(input bit r, a, st, e, se, input logic [W-1:0] dd, sdd, input logic [CH*16-1:0] ss);
        logic [W-1:0] w, x;
        int v;
        @(posedge clk);
        #1;
        compared++;
        if (align_state !== 2'(mstate)) begin
            fails++;
            $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, align_state, mstate);
        end
        compared++;
        if (align_err !== merr) begin
            fails++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, align_err, merr);
        end
        rst_n = r; arst = a; start = st; den = e; sen = se; d = dd; sd = sdd; set = ss;
        w = se ? sdd : dd;
        if (!r || a) begin
            mstate = 0;
            merr = 1'b0;
            kill();
            zero_due = cyc + 1;
        end else if (mstate == 0) begin
            if (st) begin
                mdmax = 0;
                for (int c = 0; c < CH; c++) begin
                    v = int'(ss[c*16 +: 16]);
                    md[c] = (v > DEPTH - 1) ? DEPTH - 1 : v;
                    if (v > DEPTH - 1) merr = 1'b1;
                    if (md[c] > mdmax) mdmax = md[c];
                end
                n = 0;
                hist.delete();
                mstate = 1;
            end
        end else if (!st) begin
            mstate = 0;
            kill();
        end else begin
            if (e || se) begin
                hist.push_back(w);
                if (mstate == 2) begin
                    for (int c = 0; c < CH; c++) x[c*DW +: DW] = hist[n - md[c]][c*DW +: DW];
                    q.push_back('{cyc + 2, x});
                end
                n++;
            end
            if (mstate == 1 && n >= mdmax) mstate = 2;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        logic [CH*16-1:0] s1;
        int r;
        bit st;
        rst_n = 0; arst = 0; start = 0; den = 0; sen = 0; d = '0; sd = '0; set = '0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, '0, '0, '0);
        idle(2);

        s1 = {16'd15, 16'd5, 16'd1, 16'd0};
        for (int i = 0; i < 40; i++) step(1, 0, 1, 1, 0, {CH{32'(i)}}, '0, s1);
        idle(2);

        for (int i = 0; i < 45; i++) step(1, 0, 1, i % 3 == 0, 0, rnd(), rnd(), {CH{16'd3}});
        idle(2);

        s1 = {16'd2, 16'd40, 16'd7, 16'd1};
        for (int i = 0; i < 30; i++) step(1, 0, 1, $urandom_range(0, 1) == 1, 0, rnd(), rnd(), i == 0 ? s1 : rset(60));
        idle(1);
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 0, rnd(), rnd(), {16'd4, 16'd3, 16'd2, 16'd1});
        step(1, 1, 1, 1, 0, rnd(), rnd(), '0);
        for (int i = 0; i < 12; i++) step(1, 0, 1, i > 2, 0, rnd(), rnd(), {16'd0, 16'd2, 16'd0, 16'd1});
        idle(2);

        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, '0, '0, '0);
        step(1, 0, 1, 1, 1, {CH{32'hAAAA_AAAA}}, {CH{32'h5555_5555}}, '0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, '0, '0, '0);
        step(1, 0, 1, 0, 1, rnd(), rnd(), '0);
        step(1, 0, 1, 1, 0, rnd(), rnd(), '0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, '0, '0, '0);
        idle(2);

        for (int i = 0; i < 8; i++) step(1, 0, 1, i % 2 == 0, 0, rnd(), rnd(), {CH{16'd15}});
        step(0, 0, 1, 1, 0, rnd(), rnd(), {CH{16'd15}});
        for (int i = 0; i < 25; i++) step(1, 0, 1, 1, 0, rnd(), rnd(), {16'd9, 16'd15, 16'd0, 16'd6});

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            st = !(r >= 1 && r <= 3);
            step(1, r == 0, st, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, rnd(), rnd(), rset(20));
        end

        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, '0, '0, '0);
        @(posedge clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end
endmodule
